inst_fetch: RTL

//   Instruction fetch unit: the upstream producer for the decode stage. Issues sequential 32-bit

---
 rtl/inst_fetch.sv | 139 +++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit feeding decode through an in-order fetch queue
//
// Issues one sequential fetch at a time to the memory controller, queues the returned
// {pc, inst} pairs and hands one per cycle to decode. A flush or decode redirect empties
// the queue, retargets fetch and discards any response still in flight.
//
// Ports:
//   clk, rst_in          clock (rising edge), asynchronous active-high reset
//   rdy_in               global enable; low freezes every register
//   mem_req, mem_addr    fetch request, held with a stable address until mem_done
//   mem_done, mem_data   one-cycle response strobe and fetched instruction
//   flush, flush_pc      ROB mispredict restart (wins over a decode redirect)
//   dec_upd, dec_pc      decode-predicted jump/branch restart
//   dec_ready            decode can accept an instruction this cycle
//   if2dec               one-cycle valid for pc_out/inst_out
//   pc_out, inst_out     delivered instruction and its pc
module inst_fetch #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_done,
  input  logic [INST_WIDTH-1:0] mem_data,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  dec_upd,
  input  logic [ADDR_WIDTH-1:0] dec_pc,
  input  logic                  dec_ready,
  output logic                  if2dec,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [INST_WIDTH-1:0] inst_out
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
  logic [INST_WIDTH-1:0] q_inst [QUEUE_DEPTH];

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] target;
  logic                  do_push;
  logic                  do_pop;

  assign redirect = flush | dec_upd;
  assign target   = flush ? flush_pc : dec_pc;
  // Only a WAIT response is kept; a redirect in the same cycle makes it stale.
  assign do_push  = (state == S_WAIT) && mem_done && !redirect;
  // Pop looks at the registered count, so a push lands one cycle before it can leave.
  assign do_pop   = (count != '0) && dec_ready && !redirect;

  // Queue storage needs no reset: count/head/tail decide what is valid.
  always_ff @(posedge clk) begin
    if (rdy_in && do_push) begin
      q_pc[tail]   <= fetch_pc;
      q_inst[tail] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      if2dec   <= 1'b0;
      pc_out   <= '0;
      inst_out <= '0;
    end else if (rdy_in) begin
      case (state)
        S_IDLE: begin
          if (!redirect && count < DEPTH_C) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
            if (!redirect) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
          end else if (redirect) begin
            // Request stays up until the controller answers; its data is then dropped.
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (redirect) begin
        fetch_pc <= target;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (do_push) tail <= tail + PW'(1);
        if (do_pop)  head <= head + PW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      if (do_pop) begin
        if2dec   <= 1'b1;
        pc_out   <= q_pc[head];
        inst_out <= q_inst[head];
      end else begin
        if2dec <= 1'b0;
      end
    end
  end

endmodule
